// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths and the completer FSM state type.
// Reused by the APB master for its own widths.
package apb_pkg;

  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_ADDR_W = 32;

  typedef enum logic [0:0] {
    IDLE,
    ACCESS
  } apb_slv_state_t;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a requester and the register-file completer.
// Signals: PADDR/PSEL/PENABLE/PWRITE/PWDATA (requester -> completer),
//          PRDATA/PREADY/PSLVERR (completer -> requester).
interface apb_slave_regfile_if;
  import apb_pkg::*;

  logic [APB_ADDR_W-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [APB_DATA_W-1:0] PWDATA;
  logic [APB_DATA_W-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_wait_counter.sv
// Loadable down-counter with a zero flag, used to insert APB wait states.
// Ports: PCLK, PRESETn (async active-low), load_i/load_val_i (load a new count),
//        dec_i (decrement, saturating at zero), zero_o (count is zero).
module apb_wait_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a word-addressed register file.
// Ports: PCLK, PRESETn (async active-low), apb (slave modport of the APB bundle),
//        status_in (read-only word at index NUM_REGS-1), ctrl_out (register 0).
// Index NUM_REGS-1 reads status_in and rejects writes; misaligned or out-of-range
// addresses return PSLVERR with PRDATA = 0.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  apb_slave_regfile_if.slave    apb,
  input  logic [APB_DATA_W-1:0] status_in,
  output logic [APB_DATA_W-1:0] ctrl_out
);

  localparam int unsigned IDX_W    = $clog2(NUM_REGS);
  localparam int unsigned STAT_IDX = NUM_REGS - 1;

  apb_slv_state_t        state_q, state_d;
  logic [APB_ADDR_W-1:0] addr_q;
  logic                  write_q;
  logic [APB_DATA_W-1:0] wdata_q;
  // Only the writable registers are stored; the top index is status_in.
  logic [APB_DATA_W-1:0] regs_q [NUM_REGS-1];

  logic                  setup, latch, cnt_zero, ready, complete, err;
  logic [IDX_W-1:0]      idx;
  logic [APB_DATA_W-1:0] rd_data;

  assign setup = apb.PSEL && !apb.PENABLE;

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        // PSEL with PENABLE already high is a protocol violation and is ignored.
        if (setup) begin
          state_d = ACCESS;
          latch   = 1'b1;
        end
      end
      ACCESS: begin
        if (!apb.PSEL) begin
          state_d = IDLE;
        end else if (ready && apb.PENABLE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        addr_q  <= apb.PADDR;
        write_q <= apb.PWRITE;
        wdata_q <= apb.PWDATA;
      end
    end
  end

  apb_wait_counter #(
    .WIDTH (4)
  ) u_wait_cnt (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .load_i     (latch),
    .load_val_i (4'(WAIT_CYCLES)),
    .dec_i      (state_q == ACCESS),
    .zero_o     (cnt_zero)
  );

  assign ready    = (state_q == ACCESS) && cnt_zero;
  assign complete = ready && apb.PSEL && apb.PENABLE;

  assign idx = addr_q[IDX_W+1:2];
  assign err = (addr_q[1:0] != 2'b00) ||
               (addr_q >= APB_ADDR_W'(4 * NUM_REGS)) ||
               (write_q && (idx == IDX_W'(STAT_IDX)));

  always_comb begin
    rd_data = status_in;
    for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
      if (idx == IDX_W'(i)) rd_data = regs_q[i];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int unsigned i = 0; i < NUM_REGS - 1; i++) regs_q[i] <= '0;
    end else if (complete && write_q && !err) begin
      for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
        if (idx == IDX_W'(i)) regs_q[i] <= wdata_q;
      end
    end
  end

  assign apb.PREADY  = ready;
  assign apb.PSLVERR = complete && err;
  assign apb.PRDATA  = (complete && !write_q && !err) ? rd_data : '0;
  assign ctrl_out    = regs_q[0];

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (0, 3 and 2 wait states) share
// the bus signals, each with its own PSEL and reset. Table vectors, hand
// sequences for multi-cycle corners, then random traffic against a model.
module tb_apb_slave_regfile;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  int          tgt;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, stat;
  logic [2:0]  pready, pslverr;
  logic [31:0] prdata [3];
  logic [31:0] ctrl [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wcyc [3] = '{0, 3, 2};
  logic [31:0] mregs [3][16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_slave_regfile_if bus0 ();
  apb_slave_regfile_if bus1 ();
  apb_slave_regfile_if bus2 ();

  assign bus0.PSEL = psel && (tgt == 0);
  assign bus1.PSEL = psel && (tgt == 1);
  assign bus2.PSEL = psel && (tgt == 2);
  assign {bus0.PENABLE, bus1.PENABLE, bus2.PENABLE} = {3{penable}};
  assign {bus0.PWRITE, bus1.PWRITE, bus2.PWRITE}    = {3{pwrite}};
  assign bus0.PADDR = paddr;
  assign bus1.PADDR = paddr;
  assign bus2.PADDR = paddr;
  assign bus0.PWDATA = pwdata;
  assign bus1.PWDATA = pwdata;
  assign bus2.PWDATA = pwdata;
  assign pready  = {bus2.PREADY, bus1.PREADY, bus0.PREADY};
  assign pslverr = {bus2.PSLVERR, bus1.PSLVERR, bus0.PSLVERR};
  assign prdata[0] = bus0.PRDATA;
  assign prdata[1] = bus1.PRDATA;
  assign prdata[2] = bus2.PRDATA;

  apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(0)) u_dut0 (
    .PCLK(clk), .PRESETn(rst_n[0]), .apb(bus0), .status_in(stat), .ctrl_out(ctrl[0]));
  apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(3)) u_dut1 (
    .PCLK(clk), .PRESETn(rst_n[1]), .apb(bus1), .status_in(stat), .ctrl_out(ctrl[1]));
  apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(2)) u_dut2 (
    .PCLK(clk), .PRESETn(rst_n[2]), .apb(bus2), .status_in(stat), .ctrl_out(ctrl[2]));

  typedef struct {
    int          k;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] st;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference behaviour of one completed transfer.
  function automatic void model(input int k, input bit wr, input logic [31:0] addr,
                                output logic [31:0] rd, output bit err);
    int idx;
    idx = int'(addr[5:2]);
    err = (addr % 4 != 0) || (addr >= 64) || (wr && idx == 15);
    if (wr || err) rd = 0;
    else if (idx == 15) rd = stat;
    else rd = mregs[k][idx];
  endfunction

  task automatic bus_idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // One transfer; leaves the bus in ACCESS so a following call is back-to-back.
  task automatic xfer(input int k, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit scramble,
                      output logic [31:0] rd, output bit err, output int waits);
    bit done;
    @(posedge clk); #1;
    tgt = k; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge clk);
    check("setup_pready", {31'b0, pready[k]}, 32'd0);
    @(posedge clk); #1;
    penable = 1'b1;
    if (scramble) begin
      paddr  = addr ^ 32'h4;
      pwdata = ~wdata;
    end
    waits = 0; rd = 0; err = 0; done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (pready[k]) begin
        rd = prdata[k]; err = pslverr[k]; done = 1;
      end else begin
        waits++;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout: got no PREADY want PREADY within 40 cycles (inst %0d)", k);
      waits = -1;
    end
  endtask

  task automatic run_check(input string name, input int k, input bit wr,
                           input logic [31:0] addr, input logic [31:0] wdata, input bit scr,
                           input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] rd;
    bit          err;
    int          waits;
    xfer(k, wr, addr, wdata, scr, rd, err, waits);
    check({name, "_rdata"}, rd, exp_rd);
    check({name, "_slverr"}, {31'b0, err}, {31'b0, exp_err});
    check({name, "_waits"}, waits, wcyc[k]);
    if (wr && !exp_err) mregs[k][addr[5:2]] = wdata;
    bus_idle();
    @(negedge clk);
    check({name, "_ctrl"}, ctrl[k], mregs[k][0]);
  endtask

  vec_t vecs [$];

  initial begin
    logic [31:0] rd, erd, a, d;
    bit          err, eerr, wr;
    int          waits, c1, c2, k;

    rst_n = 3'b000; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    stat = 0; tgt = 0;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 16; j++) mregs[i][j] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_pready", {31'b0, pready[i]}, 32'd0);
      check("rst_slverr", {31'b0, pslverr[i]}, 32'd0);
      check("rst_prdata", prdata[i], 32'd0);
      check("rst_ctrl", ctrl[i], 32'd0);
    end
    @(posedge clk); #1 rst_n = 3'b111;

    // Directed vectors: {inst, write, addr, wdata, status, exp rdata, exp err}
    vecs.push_back('{0, 1, 32'h04, 32'hDEADBEEF, 32'h0, 32'h0, 0});
    vecs.push_back('{0, 0, 32'h04, 32'h0, 32'h0, 32'hDEADBEEF, 0});
    vecs.push_back('{0, 0, 32'h00, 32'h0, 32'h0, 32'h0, 0});
    vecs.push_back('{1, 1, 32'h00, 32'h12345678, 32'h0, 32'h0, 0});
    vecs.push_back('{0, 0, 32'h02, 32'h0, 32'h0, 32'h0, 1});
    vecs.push_back('{0, 1, 32'h40, 32'h55555555, 32'h0, 32'h0, 1});
    vecs.push_back('{0, 1, 32'h3C, 32'h77777777, 32'h0, 32'h0, 1});
    vecs.push_back('{0, 0, 32'h3C, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0});
    vecs.push_back('{0, 0, 32'h04, 32'h0, 32'h0, 32'hDEADBEEF, 0});
    vecs.push_back('{0, 0, 32'h00, 32'h0, 32'h0, 32'h0, 0});
    vecs.push_back('{1, 0, 32'h00, 32'h0, 32'h0, 32'h12345678, 0});
    vecs.push_back('{2, 0, 32'h3C, 32'h0, 32'h0F0F0F0F, 32'h0F0F0F0F, 0});
    for (int i = 0; i < vecs.size(); i++) begin
      stat = vecs[i].st;
      run_check($sformatf("vec%0d", i), vecs[i].k, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                1'b0, vecs[i].exp_rd, vecs[i].exp_err);
    end

    // Back-to-back: write then read with no idle cycle between.
    xfer(0, 1, 32'h08, 32'h1, 1'b0, rd, err, waits);
    c1 = cyc;
    check("b2b_wr_err", {31'b0, err}, 32'd0);
    mregs[0][2] = 32'h1;
    xfer(0, 0, 32'h08, 32'h0, 1'b0, rd, err, waits);
    c2 = cyc;
    check("b2b_rd_data", rd, 32'h1);
    check("b2b_cycles", c2 - c1, 32'd2);
    bus_idle();

    // Abort: PSEL drops during the wait states of a write.
    @(posedge clk); #1;
    tgt = 2; psel = 1; penable = 0; pwrite = 1; paddr = 32'h0C; pwdata = 32'hCAFEF00D;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1 psel = 0; penable = 0;
    repeat (2) @(posedge clk);
    run_check("abort_rd", 2, 0, 32'h0C, 32'h0, 1'b0, 32'h0, 0);

    // Address and data changes during ACCESS must not matter.
    run_check("scr_wr", 1, 1, 32'h10, 32'h11112222, 1'b1, 32'h0, 0);
    run_check("scr_rd10", 1, 0, 32'h10, 32'h0, 1'b0, 32'h11112222, 0);
    run_check("scr_rd14", 1, 0, 32'h14, 32'h0, 1'b0, 32'h0, 0);

    // PSEL+PENABLE while idle is ignored.
    @(posedge clk); #1;
    tgt = 0; psel = 1; penable = 1; pwrite = 1; paddr = 32'h04; pwdata = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("viol_pready", {31'b0, pready[0]}, 32'd0);
    end
    bus_idle();
    run_check("viol_rd", 0, 0, 32'h04, 32'h0, 1'b0, 32'hDEADBEEF, 0);

    // Random traffic against the model.
    for (int n = 0; n < 150; n++) begin
      k  = int'($urandom_range(0, 2));
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      case ($urandom_range(0, 9))
        7:       a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
        8:       a = 32'h40 + 32'($urandom_range(0, 1000)) * 4;
        9:       a = $urandom;
        default: a = 32'($urandom_range(0, 15)) * 4;
      endcase
      stat = $urandom;
      model(k, wr, a, erd, eerr);
      run_check($sformatf("rnd%0d", n), k, wr, a, d, 1'($urandom_range(0, 1)), erd, eerr);
    end

    // Reset asserted while PREADY is high on a write: write lost, all cleared.
    @(posedge clk); #1;
    tgt = 0; psel = 1; penable = 0; pwrite = 1; paddr = 32'h18; pwdata = 32'h0000ABCD;
    @(posedge clk); #1 penable = 1;
    @(negedge clk);
    check("prerst_pready", {31'b0, pready[0]}, 32'd1);
    #1 rst_n[0] = 1'b0;
    #1 check("rst_mid_pready", {31'b0, pready[0]}, 32'd0);
    check("rst_mid_ctrl", ctrl[0], 32'd0);
    psel = 0; penable = 0;
    @(posedge clk); #1 rst_n[0] = 1'b1;
    for (int j = 0; j < 16; j++) mregs[0][j] = 0;
    for (int j = 0; j < 15; j++)
      run_check($sformatf("postrst%0d", j), 0, 0, 32'(j * 4), 32'h0, 1'b0, 32'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
